// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals shared by mem_arbiter.
// The master modport is the requester/memory environment; slave is the arbiter.
interface mem_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory among NREQ
// requesters, one access in flight, with per-port grant and completion pulses.
module mem_arbiter #(
    parameter int NREQ    = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MEM_LAT + 1);
    // Port 2 is the instruction fetch port and can never write.
    localparam logic [NREQ-1:0] RO_MASK = NREQ'(3'b100);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [LW-1:0]   r_last;
    logic [LW-1:0]   r_cur;
    logic            r_weLatched;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_rvalid;
    logic [DW-1:0]   r_rdata;
    logic            r_memEn;
    logic            r_memWe;
    logic [AW-1:0]   r_memAddr;
    logic [DW-1:0]   r_memWdata;

    logic [NREQ-1:0] w_weEff;
    logic            w_found;
    logic [LW-1:0]   w_win;
    int              w_idx;

    assign w_weEff = bus.we & ~RO_MASK;

    // Scan starting just after the last winner so every requester is served within NREQ grants.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_last) + k) % NREQ;
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = LW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last      <= LW'(NREQ - 1);
            r_cur       <= '0;
            r_weLatched <= 1'b0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_rdata     <= '0;
            r_memEn     <= 1'b0;
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_memEn  <= 1'b0;
            r_memWe  <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_found) begin
                        r_gnt       <= NREQ'(1) << w_win;
                        r_memEn     <= 1'b1;
                        r_memWe     <= w_weEff[w_win];
                        r_weLatched <= w_weEff[w_win];
                        r_memAddr   <= bus.addr[int'(w_win)*AW +: AW];
                        r_memWdata  <= bus.wdata[int'(w_win)*DW +: DW];
                        r_last      <= w_win;
                        r_cur       <= w_win;
                        r_cnt       <= CW'(MEM_LAT);
                        r_state     <= WAIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    // Capture one edge after the count expires, when mem_rdata has been valid a full cycle.
                    if (r_cnt == '0) begin
                        r_rdata  <= r_weLatched ? '0 : bus.mem_rdata;
                        r_rvalid <= NREQ'(1) << r_cur;
                        r_state  <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rvalid    = r_rvalid;
    assign bus.rdata     = r_rdata;
    assign bus.mem_en    = r_memEn;
    assign bus.mem_we    = r_memWe;
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_wdata = r_memWdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Drives two arbiters (memory latency 1 and 3) with identical stimulus and
// compares them against a transaction-timeline reference model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  tbReq = '0;
    logic [2:0]  tbWe = '0;
    logic [95:0] tbAddr = '0;
    logic [95:0] tbWdata = '0;

    mem_arbiter_if #(.NREQ(3), .AW(32), .DW(32)) ifA ();
    mem_arbiter_if #(.NREQ(3), .AW(32), .DW(32)) ifB ();

    mem_arbiter #(.NREQ(3), .AW(32), .DW(32), .MEM_LAT(1)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(ifA.slave));
    mem_arbiter #(.NREQ(3), .AW(32), .DW(32), .MEM_LAT(3)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(ifB.slave));

    assign ifA.req = tbReq;
    assign ifA.we = tbWe;
    assign ifA.addr = tbAddr;
    assign ifA.wdata = tbWdata;
    assign ifB.req = tbReq;
    assign ifB.we = tbWe;
    assign ifB.addr = tbAddr;
    assign ifB.wdata = tbWdata;

    // Behavioural memories: data valid MEM_LAT cycles after mem_en, garbage otherwise.
    logic [31:0] devA [32];
    logic [31:0] devB [32];
    logic [31:0] pipeA;
    logic [31:0] pipeB [3];
    assign ifA.mem_rdata = pipeA;
    assign ifB.mem_rdata = pipeB[2];

    always @(posedge clk) begin
        if (ifA.mem_en && ifA.mem_we) devA[ifA.mem_addr[6:2]] <= ifA.mem_wdata;
        pipeA <= (ifA.mem_en && !ifA.mem_we) ? devA[ifA.mem_addr[6:2]] : $urandom;
        if (ifB.mem_en && ifB.mem_we) devB[ifB.mem_addr[6:2]] <= ifB.mem_wdata;
        pipeB[0] <= (ifB.mem_en && !ifB.mem_we) ? devB[ifB.mem_addr[6:2]] : $urandom;
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end

    int compared = 0;
    int mismatched = 0;

    // Reference model state, indexed by instance (0: latency 1, 1: latency 3).
    int          lat [2] = '{1, 3};
    logic [31:0] shadow [2][32];
    int          last [2];
    bit          pending [2];
    longint      compEdge [2];
    int          compPort [2];
    logic [31:0] compData [2];
    logic [2:0]  expGnt [2];
    logic [2:0]  expRvalid [2];
    logic [31:0] expRdata [2];
    logic        expEn [2];
    logic        expWe [2];
    logic [31:0] expAddr [2];
    logic [31:0] expWdata [2];
    longint      edgeNo = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (edge %0d)", tag, observed, expected, edgeNo);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            last[i] = 2;
            pending[i] = 0;
            expGnt[i] = '0;
            expRvalid[i] = '0;
            expEn[i] = 0;
            expWe[i] = 0;
        end
    endtask

    // One clock edge of the reference: an access occupies the memory from its
    // grant until its completion edge, grant+latency+1.
    task automatic modelStep(input int i);
        bit found;
        int winner;
        int p;
        bit wr;
        logic [31:0] a;
        logic [31:0] d;
        expGnt[i] = '0;
        expRvalid[i] = '0;
        expEn[i] = 0;
        expWe[i] = 0;
        if (pending[i]) begin
            if (edgeNo == compEdge[i]) begin
                expRvalid[i] = 3'(1 << compPort[i]);
                expRdata[i] = compData[i];
                pending[i] = 0;
            end
        end else begin
            found = 0;
            winner = 0;
            for (int k = 1; k <= 3; k++) begin
                p = (last[i] + k) % 3;
                if (!found && tbReq[p]) begin
                    found = 1;
                    winner = p;
                end
            end
            if (found) begin
                wr = (winner != 2) && tbWe[winner];
                a = tbAddr[winner*32 +: 32];
                d = tbWdata[winner*32 +: 32];
                expGnt[i] = 3'(1 << winner);
                expEn[i] = 1;
                expWe[i] = wr;
                expAddr[i] = a;
                expWdata[i] = d;
                last[i] = winner;
                pending[i] = 1;
                compEdge[i] = edgeNo + lat[i] + 1;
                compPort[i] = winner;
                compData[i] = wr ? 32'h0 : shadow[i][a[6:2]];
                if (wr) shadow[i][a[6:2]] = d;
            end
        end
    endtask

    task automatic checkInstance(input int i, input logic [2:0] g, input logic [2:0] rv,
                                 input logic [31:0] rd, input logic en, input logic we,
                                 input logic [31:0] ad, input logic [31:0] wd);
        checkOutput($sformatf("i%0d gnt", i), 32'(g), 32'(expGnt[i]));
        checkOutput($sformatf("i%0d rvalid", i), 32'(rv), 32'(expRvalid[i]));
        checkOutput($sformatf("i%0d mem_en", i), 32'(en), 32'(expEn[i]));
        checkOutput($sformatf("i%0d onehot", i), 32'($countones(g | rv) <= 1), 32'd1);
        if (expEn[i]) begin
            checkOutput($sformatf("i%0d mem_we", i), 32'(we), 32'(expWe[i]));
            checkOutput($sformatf("i%0d mem_addr", i), ad, expAddr[i]);
            checkOutput($sformatf("i%0d mem_wdata", i), wd, expWdata[i]);
        end
        if (expRvalid[i] != 0) checkOutput($sformatf("i%0d rdata", i), rd, expRdata[i]);
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [2:0] w,
                                 input int port, input logic [31:0] a, input logic [31:0] d);
        tbReq = r;
        tbWe = w;
        tbAddr[port*32 +: 32] = a;
        tbWdata[port*32 +: 32] = d;
    endtask

    task automatic cycle();
        @(posedge clk);
        edgeNo++;
        if (rst_n) begin
            modelStep(0);
            modelStep(1);
        end
        @(negedge clk);
        checkInstance(0, ifA.gnt, ifA.rvalid, ifA.rdata, ifA.mem_en, ifA.mem_we, ifA.mem_addr, ifA.mem_wdata);
        checkInstance(1, ifB.gnt, ifB.rvalid, ifB.rdata, ifB.mem_en, ifB.mem_we, ifB.mem_addr, ifB.mem_wdata);
    endtask

    task automatic idle(input int n);
        tbReq = '0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, " A gnt|rvalid|en|we"}, 32'({ifA.gnt, ifA.rvalid, ifA.mem_en, ifA.mem_we}), 32'h0);
        checkOutput({tag, " A rdata"}, ifA.rdata, 32'h0);
        checkOutput({tag, " A mem_addr"}, ifA.mem_addr, 32'h0);
        checkOutput({tag, " B gnt|rvalid|en|we"}, 32'({ifB.gnt, ifB.rvalid, ifB.mem_en, ifB.mem_we}), 32'h0);
        checkOutput({tag, " B mem_wdata"}, ifB.mem_wdata, 32'h0);
    endtask

    logic [2:0] gq [$];
    longint     cq [$];
    int         port1Grants;

    initial begin
        for (int j = 0; j < 32; j++) begin
            logic [31:0] v;
            v = (j == 16) ? 32'hDEADBEEF : $urandom;
            devA[j] = v;
            devB[j] = v;
            shadow[0][j] = v;
            shadow[1][j] = v;
        end
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkZeroOutputs("reset");
        rst_n = 1'b1;

        // Single read on port 0, latency 1: grant in T, completion in T+2.
        applyStimulus(3'b001, 3'b000, 0, 32'h40, 32'h0);
        cycle();
        checkOutput("t1 gnt", 32'(ifA.gnt), 32'h1);
        checkOutput("t1 mem_en", 32'(ifA.mem_en), 32'h1);
        checkOutput("t1 mem_addr", ifA.mem_addr, 32'h40);
        tbReq = '0;
        cycle();
        cycle();
        checkOutput("t1 rvalid", 32'(ifA.rvalid), 32'h1);
        checkOutput("t1 rdata", ifA.rdata, 32'hDEADBEEF);
        idle(6);

        // All ports held: grants rotate and are MEM_LAT+2 cycles apart.
        applyStimulus(3'b111, 3'b000, 1, 32'h8, 32'h0);
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (ifA.gnt != 0) begin
                gq.push_back(ifA.gnt);
                cq.push_back(edgeNo);
            end
        end
        checkOutput("t2 count", 32'(gq.size() >= 4), 32'd1);
        for (int k = 1; k < gq.size(); k++) begin
            checkOutput("t2 rotate", 32'(gq[k]), 32'({gq[k-1][1:0], gq[k-1][2]}));
            checkOutput("t2 spacing", 32'(cq[k] - cq[k-1]), 32'd3);
        end
        idle(8);

        // Port 1 write: completes with rdata 0.
        applyStimulus(3'b010, 3'b010, 1, 32'h10, 32'h1234);
        cycle();
        checkOutput("t3 gnt", 32'(ifA.gnt), 32'h2);
        checkOutput("t3 mem_we", 32'(ifA.mem_we), 32'h1);
        checkOutput("t3 mem_wdata", ifA.mem_wdata, 32'h1234);
        tbReq = '0;
        cycle();
        cycle();
        checkOutput("t3 rvalid", 32'(ifA.rvalid), 32'h2);
        checkOutput("t3 rdata", ifA.rdata, 32'h0);
        idle(8);

        // Port 2 cannot write; latency 3 instance completes in T+4 only.
        applyStimulus(3'b100, 3'b100, 2, 32'h10, 32'hCAFE);
        cycle();
        checkOutput("t4 gnt", 32'(ifB.gnt), 32'h4);
        checkOutput("t4 mem_we", 32'(ifB.mem_we), 32'h0);
        tbReq = '0;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            checkOutput($sformatf("t4 rvalid T+%0d", k), 32'(ifB.rvalid), (k == 4) ? 32'h4 : 32'h0);
        end
        checkOutput("t4 rdata", ifB.rdata, 32'h1234);
        idle(8);

        // Reset in the middle of an access drops it; arbitration restarts at port 0.
        applyStimulus(3'b010, 3'b000, 1, 32'h20, 32'h0);
        cycle();
        cycle();
        applyStimulus(3'b101, 3'b000, 0, 32'h24, 32'h0);
        tbReq = '0;
        rst_n = 1'b0;
        #1;
        checkZeroOutputs("t5 async");
        modelReset();
        cycle();
        tbReq = 3'b101;
        rst_n = 1'b1;
        cycle();
        checkOutput("t5 A first", 32'(ifA.gnt), 32'h1);
        checkOutput("t5 B first", 32'(ifB.gnt), 32'h1);
        tbReq = '0;
        idle(8);

        // Port 1 request withdrawn while port 0 busy is never granted.
        port1Grants = 0;
        applyStimulus(3'b001, 3'b000, 0, 32'h44, 32'h0);
        cycle();
        applyStimulus(3'b010, 3'b000, 1, 32'h48, 32'h0);
        cycle();
        if (ifA.gnt[1]) port1Grants++;
        tbReq = '0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (ifA.gnt[1]) port1Grants++;
        end
        checkOutput("t6 port1 grants", 32'(port1Grants), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            tbReq = 3'($urandom_range(0, 7));
            tbWe = 3'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) begin
                tbAddr[p*32 +: 32] = {25'b0, 5'($urandom_range(0, 31)), 2'b00};
                tbWdata[p*32 +: 32] = $urandom;
            end
            cycle();
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
